// File: rtl/fpu_cvt_if.sv
// Request/response handshake bundle for the int32 <-> float32 converter.
interface fpu_cvt_if;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [1:0]  o_flags;

  modport master (
    output i_valid, i_op, i_data, i_ready,
    input  o_ready, o_valid, o_result, o_flags
  );

  modport slave (
    input  i_valid, i_op, i_data, i_ready,
    output o_ready, o_valid, o_result, o_flags
  );
endinterface

// File: rtl/fpu_cvt.sv
// Iterative int32 <-> IEEE-754 single converter (fcvt.s.w/wu, fcvt.w/wu.s).
// One operation in flight; the normalise/denormalise shift runs SHIFT_STEP bits per cycle.
module fpu_cvt #(
  parameter int SHIFT_STEP = 1
) (
  input logic     i_clk,
  input logic     i_rsn,
  fpu_cvt_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg;
  logic        sign_reg;
  logic [31:0] mag_reg;
  logic        sticky_reg;
  logic [5:0]  cnt_reg;
  logic [7:0]  exp_reg;
  logic        spec_reg;
  logic [31:0] spec_res_reg;
  logic [1:0]  spec_flags_reg;
  logic [31:0] result_reg;
  logic [1:0]  flags_reg;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n;
  endfunction

  logic        int_sign;
  logic [31:0] int_mag;
  logic [5:0]  int_lz;
  logic [7:0]  f_exp;
  logic [22:0] f_frac;
  logic [7:0]  f_shift;

  assign int_sign = ~bus.i_op[0] & bus.i_data[31];
  assign int_mag  = int_sign ? (~bus.i_data + 32'd1) : bus.i_data;
  assign int_lz   = clz32(int_mag);
  assign f_exp    = bus.i_data[30:23];
  assign f_frac   = bus.i_data[22:0];
  assign f_shift  = 8'd158 - f_exp;

  logic        acc_sign, acc_spec;
  logic [31:0] acc_mag, acc_spec_res;
  logic [5:0]  acc_cnt;
  logic [7:0]  acc_exp;
  logic [1:0]  acc_spec_flags;

  // Operand decode at accept: special/saturating cases skip the shifter (n = 0).
  always_comb begin
    acc_sign       = 1'b0;
    acc_mag        = 32'd0;
    acc_cnt        = 6'd0;
    acc_exp        = 8'd0;
    acc_spec       = 1'b0;
    acc_spec_res   = 32'd0;
    acc_spec_flags = 2'b00;
    if (!bus.i_op[1]) begin
      acc_sign = int_sign;
      acc_mag  = int_mag;
      acc_spec = (int_mag == 32'd0);
      acc_cnt  = acc_spec ? 6'd0 : int_lz;
      acc_exp  = 8'd158 - {2'b00, acc_cnt};
    end else begin
      acc_sign = bus.i_data[31];
      acc_mag  = {1'b1, f_frac, 8'd0};
      if (f_exp == 8'hFF && f_frac != 23'd0) begin
        acc_spec       = 1'b1;
        acc_spec_res   = bus.i_op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        acc_spec_flags = 2'b10;
      end else if (f_exp < 8'd127) begin
        acc_spec       = 1'b1;
        acc_spec_flags = {1'b0, bus.i_data[30:0] != 31'd0};
      end else if (!bus.i_op[0]) begin
        if (f_exp >= 8'd158) begin
          acc_spec = 1'b1;
          if (bus.i_data == 32'hCF00_0000) begin
            acc_spec_res = 32'h8000_0000;
          end else begin
            acc_spec_res   = bus.i_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            acc_spec_flags = 2'b10;
          end
        end else begin
          acc_cnt = f_shift[5:0];
        end
      end else begin
        if (bus.i_data[31]) begin
          acc_spec       = 1'b1;
          acc_spec_flags = 2'b10;
        end else if (f_exp >= 8'd159) begin
          acc_spec       = 1'b1;
          acc_spec_res   = 32'hFFFF_FFFF;
          acc_spec_flags = 2'b10;
        end else begin
          acc_cnt = f_shift[5:0];
        end
      end
    end
  end

  logic [5:0]  step;
  logic [31:0] out_mask;
  logic [31:0] lsh, rsh;

  assign step = (cnt_reg < 6'(SHIFT_STEP)) ? cnt_reg : 6'(SHIFT_STEP);
  assign lsh  = mag_reg << step;
  assign rsh  = mag_reg >> step;

  // Bits that fall off the bottom this cycle feed the sticky bit.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_mask
      assign out_mask[gi] = (6'(gi) < step);
    end
  endgenerate

  logic        rnd_up;
  logic [30:0] packed_f;
  logic [31:0] int_res;

  assign rnd_up   = mag_reg[7] & ((|mag_reg[6:0]) | mag_reg[8]);
  assign packed_f = {exp_reg, mag_reg[30:8]} + {30'd0, rnd_up};
  assign int_res  = (~op_reg[0] & sign_reg) ? (~mag_reg + 32'd1) : mag_reg;

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.i_valid) state_next = SHIFT;
      SHIFT:   if (cnt_reg == 6'd0) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (bus.i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      op_reg         <= 2'b00;
      sign_reg       <= 1'b0;
      mag_reg        <= 32'd0;
      sticky_reg     <= 1'b0;
      cnt_reg        <= 6'd0;
      exp_reg        <= 8'd0;
      spec_reg       <= 1'b0;
      spec_res_reg   <= 32'd0;
      spec_flags_reg <= 2'b00;
      result_reg     <= 32'd0;
      flags_reg      <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: if (bus.i_valid) begin
          op_reg         <= bus.i_op;
          sign_reg       <= acc_sign;
          mag_reg        <= acc_mag;
          sticky_reg     <= 1'b0;
          cnt_reg        <= acc_cnt;
          exp_reg        <= acc_exp;
          spec_reg       <= acc_spec;
          spec_res_reg   <= acc_spec_res;
          spec_flags_reg <= acc_spec_flags;
        end
        SHIFT: if (cnt_reg != 6'd0) begin
          mag_reg <= op_reg[1] ? rsh : lsh;
          if (op_reg[1]) sticky_reg <= sticky_reg | (|(mag_reg & out_mask));
          cnt_reg <= cnt_reg - step;
        end
        ROUND: begin
          if (spec_reg) begin
            result_reg <= spec_res_reg;
            flags_reg  <= spec_flags_reg;
          end else if (!op_reg[1]) begin
            result_reg <= {sign_reg, packed_f};
            flags_reg  <= {1'b0, mag_reg[7] | (|mag_reg[6:0])};
          end else begin
            result_reg <= int_res;
            flags_reg  <= {1'b0, sticky_reg};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = (state_reg == IDLE);
  assign bus.o_valid  = (state_reg == DONE);
  assign bus.o_result = result_reg;
  assign bus.o_flags  = flags_reg;

endmodule

// File: tb/tb_fpu_cvt.sv
// Scoreboard bench for fpu_cvt: arithmetic reference model, random ops, backpressure and reset abort.
module tb_fpu_cvt;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  fpu_cvt_if bus();
  fpu_cvt #(.SHIFT_STEP(STEP)) dut (.i_clk(clk), .i_rsn(rsn), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] res;
    logic [1:0]  fl;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model built from the value semantics of the conversions.
  function automatic void model(input logic [1:0] op, input logic [31:0] d,
                                output logic [31:0] r, output logic [1:0] f, output int n);
    r = 32'd0; f = 2'b00; n = 0;
    if (!op[1]) begin
      bit sgn;
      longint mag, keep, rem, half;
      int p, sh;
      sgn = !op[0] && d[31];
      mag = sgn ? ((longint'(1) <<< 32) - longint'(d)) : longint'(d);
      if (mag == 0) return;
      p = 0;
      for (int i = 0; i < 33; i++) if (mag[i]) p = i;
      n = 31 - p;
      rem = 0;
      if (p <= 23) keep = mag <<< (23 - p);
      else begin
        sh   = p - 23;
        keep = mag >>> sh;
        rem  = mag - (keep <<< sh);
        half = longint'(1) <<< (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep++;
        if (keep == (longint'(1) <<< 24)) begin keep = keep >>> 1; p++; end
      end
      r = {sgn, 8'(127 + p), keep[22:0]};
      f = {1'b0, rem != 0};
    end else begin
      logic [7:0]  ex;
      logic [22:0] fr;
      bit neg, nan;
      real v, scale, t;
      ex = d[30:23]; fr = d[22:0]; neg = d[31];
      nan = (ex == 8'hFF) && (fr != 0);
      scale = 1.0;
      if (ex == 0) begin
        for (int i = 0; i < 149; i++) scale = scale / 2.0;
        v = real'(int'(fr)) * scale;
      end else if (ex == 8'hFF) v = 1.0e40;
      else begin
        if (ex >= 127) for (int i = 0; i < int'(ex) - 127; i++) scale = scale * 2.0;
        else           for (int i = 0; i < 127 - int'(ex); i++) scale = scale / 2.0;
        v = (1.0 + real'(int'(fr)) / 8388608.0) * scale;
      end
      if (neg) v = -v;
      if (ex >= 127 && ex <= 158 && !(op[0] && neg)) n = 158 - int'(ex);
      if (!op[0]) begin
        if (nan)                        begin r = 32'h7FFF_FFFF; f = 2'b10; end
        else if (v >= 2147483648.0)     begin r = 32'h7FFF_FFFF; f = 2'b10; end
        else if (v < -2147483648.0)     begin r = 32'h8000_0000; f = 2'b10; end
        else if (v == -2147483648.0)    begin r = 32'h8000_0000; f = 2'b00; end
        else begin
          t = (v >= 0.0) ? $floor(v) : -$floor(-v);
          r = 32'(longint'(t));
          f = {1'b0, t != v};
        end
      end else begin
        if (nan)                        begin r = 32'hFFFF_FFFF; f = 2'b10; end
        else if (v <= -1.0)             begin r = 32'h0;         f = 2'b10; end
        else if (v >= 4294967296.0)     begin r = 32'hFFFF_FFFF; f = 2'b10; end
        else if (v < 0.0)               begin r = 32'h0;         f = 2'b01; end
        else begin
          t = $floor(v);
          r = 32'(longint'(t));
          f = {1'b0, t != v};
        end
      end
    end
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] data, input bit track);
    logic [31:0] r;
    logic [1:0]  f;
    int          n, w;
    exp_t        e;
    w = 0;
    do begin @(negedge clk); w++; end while (!bus.o_ready && w < 300);
    if (!bus.o_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    model(op, data, r, f, n);
    bus.i_op = op; bus.i_data = data; bus.i_valid = 1'b1;
    if (track) begin
      e.op = op; e.data = data; e.res = r; e.fl = f;
      e.acc = cyc + 1; e.lat = 2 + (n + STEP - 1) / STEP;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  initial begin
    bus.i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.i_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    bit in_done = 1'b0;
    int idle = 0;
    forever begin
      @(negedge clk);
      if (bus.o_valid) begin
        idle = 0;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=%h required=none", bus.o_result);
        end else begin
          if (!in_done) begin
            in_done = 1'b1;
            check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
          end
          check("result", bus.o_result, sbq[0].res);
          check("flags", {30'd0, bus.o_flags}, {30'd0, sbq[0].fl});
          if (bus.i_ready) begin
            $display("txn op=%0d data=%h result=%h flags=%b", sbq[0].op, sbq[0].data,
                     bus.o_result, bus.o_flags);
            in_done = 1'b0;
            void'(sbq.pop_front());
          end
        end
      end else if (sbq.size() != 0 && rsn) begin
        idle++;
        if (idle > 200) begin
          checks++; errors++;
          $display("FAIL result_timeout actual=no_valid required=valid");
          sbq.delete();
          idle = 0;
        end
      end
    end
  end

  function automatic logic [31:0] rand_data(input logic [1:0] op);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [31:0] d;
    if (!op[1]) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $urandom >> $urandom_range(0, 31);
        2:       d = -($urandom >> $urandom_range(0, 31));
        default: d = ($urandom_range(0, 3) == 0) ? 32'd0
                     : ((32'd1 << $urandom_range(0, 31)) | 32'($urandom_range(0, 1)));
      endcase
    end else begin
      case ($urandom_range(0, 9))
        0:       ex = 8'hFF;
        1:       ex = 8'd0;
        2:       ex = 8'(157 + $urandom_range(0, 2));
        3:       ex = 8'($urandom_range(0, 255));
        default: ex = 8'($urandom_range(120, 160));
      endcase
      fr = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
      d  = {1'($urandom_range(0, 1)), ex, fr};
    end
    return d;
  endfunction

  logic [1:0]  dir_op[15]   = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10,
                                2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
  logic [31:0] dir_data[15] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0100_0001,
                                32'h0100_0003, 32'hC070_0000, 32'h3F00_0000, 32'h7FC0_0000,
                                32'hBF80_0000, 32'h4F00_0000, 32'hCF00_0000, 32'h4F7F_FFFF,
                                32'hFFFF_FFFF, 32'hBF00_0000, 32'h0000_0000};

  initial begin
    int w;
    bus.i_valid = 1'b0; bus.i_op = 2'b00; bus.i_data = 32'd0;
    rsn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, bus.o_ready}, 32'd1);
    check("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    check("reset_result", bus.o_result, 32'd0);
    check("reset_flags", {30'd0, bus.o_flags}, 32'd0);
    rsn = 1'b1;

    for (int i = 0; i < 15; i++) send(dir_op[i], dir_data[i], 1'b1);

    w = 0;
    while (sbq.size() != 0 && w < 500) begin @(negedge clk); w++; end
    stall = 1'b1;
    send(2'b00, 32'h0100_0003, 1'b1);
    w = 0;
    while (!bus.o_valid && w < 100) begin @(negedge clk); w++; end
    repeat (5) begin
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_op = 2'b10; bus.i_data = 32'h3F80_0000;
      check("stall_ready", {31'd0, bus.o_ready}, 32'd0);
      check("stall_valid", {31'd0, bus.o_valid}, 32'd1);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    stall = 1'b0;

    w = 0;
    while (sbq.size() != 0 && w < 500) begin @(negedge clk); w++; end
    send(2'b00, 32'h0000_0001, 1'b0);
    repeat (5) @(negedge clk);
    rsn = 1'b0;
    #1;
    check("abort_valid", {31'd0, bus.o_valid}, 32'd0);
    check("abort_ready", {31'd0, bus.o_ready}, 32'd1);
    check("abort_result", bus.o_result, 32'd0);
    @(negedge clk);
    rsn = 1'b1;
    send(2'b10, 32'hC070_0000, 1'b1);

    for (int i = 0; i < 250; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      send(op, rand_data(op), 1'b1);
    end

    w = 0;
    while (sbq.size() != 0 && w < 3000) begin @(negedge clk); w++; end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_cvt.md
Name: fpu_cvt

Overview:
- Iterative int32↔float32 converter for the FPU datapath (RISC-V fcvt.s.w/wu and fcvt.w/wu.s).
- It is the reverse of the FPU's float-producing path: it packs integers into IEEE-754 single, and unpacks single back to integer.
- Multi-cycle, with a valid/ready handshake on both sides.
- Sits beside FPU32 in the execute stage and holds one operation at a time.

Parameters:
- SHIFT_STEP, 1, maximum bit positions shifted per SHIFT cycle. Legal values 1, 2, 4, 8.

Ports:
- i_clk  input  1  clock.
- i_rsn  input  1  reset. Asynchronous, active-low.
- i_valid  input  1  request valid.
- o_ready  output  1  block idle and able to accept.
- i_op  input  2  00 = int→float signed; 01 = int→float unsigned; 10 = float→int signed; 11 = float→int unsigned.
- i_data  input  32  operand (integer or float bits).
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  32  converted value.
- o_flags  output  2  {NV, NX}: invalid, inexact.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, o_ready=1, o_valid=0, o_result=0, o_flags=0.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: o_ready=1.
  - On i_valid&&o_ready, latch op/data, compute shift count n, go to SHIFT.
  - Op and data are captured only at this point.
- SHIFT: each cycle shifts min(SHIFT_STEP, remaining) positions and decrements the count. When remaining==0, go to ROUND. With n==0 it stays exactly one cycle.
- ROUND: one cycle; apply rounding, pack result and flags, go to DONE.
- DONE: o_valid=1; o_result and o_flags held stable. On i_ready go to IDLE; the next request can be accepted one cycle later.
- Latency from accept edge to o_valid high: 2 + ceil(n/SHIFT_STEP) cycles.
- int→float:
  - Signed op: magnitude = |x| (0x80000000 → 2^31).
  - Left-normalize until bit31=1; n = leading zeros of magnitude.
  - exponent = 158 − n.
  - Mantissa = bits[30:8]; guard = bit7; sticky = OR(bits[6:0]).
  - Round to nearest even. A mantissa carry-out increments the exponent.
  - Zero input → 0x00000000, n=0, no flags.
  - NX = guard|sticky. NV is never set.
- float→int:
  - e = exp − 127. Significand {1,frac} placed at bits[31:8] of a 32-bit register, plus a 1-bit sticky register.
  - 0≤e≤31: right shift n = 31−e; bits shifted out OR into sticky.
  - Round toward zero. NX = sticky.
  - Signed results are negated if sign=1.
  - e<0, including denormals: n=0, result 0, NX = (input ≠ ±0). Negative values in (−1,0) for unsigned give 0 with NX only.
- Saturation (n=0, NV=1, NX=0):
  - NaN → 0x7FFFFFFF (signed), 0xFFFFFFFF (unsigned).
  - Signed: e≥31 positive or +Inf → 0x7FFFFFFF. e≥31 negative → 0x80000000, except exactly 0xCF000000 → 0x80000000 with no flags.
  - Unsigned: e≥32 or +Inf → 0xFFFFFFFF. Any negative value ≤ −1.0, or −Inf → 0.
- Simultaneous events: i_valid while not IDLE is ignored (o_ready=0). Inputs are ignored in DONE.
- Reset mid-operation aborts immediately to the reset values; a partial result is never emitted.

Test Plan:
- op=00, data=0x00000001 → o_result=0x3F800000, flags=00, o_valid 33 cycles after accept (SHIFT_STEP=1); 10 cycles with SHIFT_STEP=4.
- op=00, data=0x80000000 → 0xCF000000, flags=00, latency 2. op=01, data=0x80000000 → 0x4F000000.
- op=00, data=0x01000001 → 0x4B800000 (tie to even), NX=1. op=00, data=0x01000003 → 0x4B800002, NX=1.
- op=10, data=0xC0700000 (−3.75) → 0xFFFFFFFD, NX=1, latency 32. op=10, data=0x3F000000 (0.5) → 0, NX=1.
- op=10, data=0x7FC00000 → 0x7FFFFFFF, NV=1. op=11, data=0xBF800000 → 0, NV=1. op=10, data=0x4F000000 → 0x7FFFFFFF, NV=1.
- Backpressure/reset:
  - Hold i_ready=0 for 5 cycles in DONE → o_valid, o_result and o_flags stable, o_ready=0; a new i_valid is ignored.
  - Deassert i_rsn mid-SHIFT → o_valid=0 and o_ready=1 at once; after release, the next request completes correctly.
